// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between a master/decoder and the ahb_slave_mem responder.
// HREADY is the muxed global ready, so it sits on the master side of the bundle.
interface ahb_slave_mem_if;
    logic        HSEL;
    logic [63:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [63:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [63:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB slave backed by a 64-bit register memory, with programmable wait states and
// two-cycle ERROR responses. Define AHB_SLAVE_RETRY_EN to add BUSY_IN and RETRY responses.
module ahb_slave_mem #(
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_STATES = 0
) (
    input  logic           CLK,
    input  logic           RST,
`ifdef AHB_SLAVE_RETRY_EN
    input  logic           BUSY_IN,
`endif
    ahb_slave_mem_if.slave ahb
);
    localparam int          AW   = $clog2(MEM_DEPTH);
    localparam logic [63:0] SPAN = 64'(MEM_DEPTH) * 64'd8;

    localparam logic [1:0] RESP_OKAY  = 2'd0;
    localparam logic [1:0] RESP_ERROR = 2'd1;
`ifdef AHB_SLAVE_RETRY_EN
    localparam logic [1:0] RESP_RETRY = 2'd2;
`endif

    typedef enum logic [2:0] {
        ST_ADDR,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
`ifdef AHB_SLAVE_RETRY_EN
        ST_ERR2,
        ST_RTY1,
        ST_RTY2
`else
        ST_ERR2
`endif
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [AW-1:0]   idx_q;
    logic [2:0]      lane_q;
    logic [1:0]      size_q;
    logic            write_q;
    logic            rdy_q;
    logic [1:0]      resp_q;
    logic [63:0]     mem_q [MEM_DEPTH];

    logic [63:0]     off;
    logic            misalign;
    logic            illegal;
    logic            accept;
    logic [7:0]      size_bytes;
    logic [7:0]      lane_mask;
    logic            unused_ok;

    assign unused_ok = ^{ahb.HBURST, ahb.HTRANS[0]};

    // Offset wraps for addresses below BASE_ADDR, so one unsigned compare covers both sides.
    assign off = ahb.HADDR - BASE_ADDR;

    always_comb begin
        case (ahb.HSIZE)
            3'd1:    misalign = ahb.HADDR[0];
            3'd2:    misalign = |ahb.HADDR[1:0];
            3'd3:    misalign = |ahb.HADDR[2:0];
            default: misalign = 1'b0;
        endcase
    end

    assign illegal = ahb.HSIZE[2] | misalign | (off >= SPAN);
    // rdy_q is high exactly in the states that may take a new address phase.
    assign accept  = rdy_q & ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_ADDR;
            cnt_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            rdy_q   <= 1'b1;
            resp_q  <= RESP_OKAY;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_DATA;
                        rdy_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state_q <= ST_ERR2;
                    rdy_q   <= 1'b1;
                end
`ifdef AHB_SLAVE_RETRY_EN
                ST_RTY1: begin
                    state_q <= ST_RTY2;
                    rdy_q   <= 1'b1;
                end
`endif
                default: begin
                    if (accept) begin
                        idx_q   <= off[AW+2:3];
                        lane_q  <= ahb.HADDR[2:0];
                        size_q  <= ahb.HSIZE[1:0];
                        write_q <= ahb.HWRITE;
                        if (illegal) begin
                            state_q <= ST_ERR1;
                            rdy_q   <= 1'b0;
                            resp_q  <= RESP_ERROR;
`ifdef AHB_SLAVE_RETRY_EN
                        end else if (BUSY_IN) begin
                            state_q <= ST_RTY1;
                            rdy_q   <= 1'b0;
                            resp_q  <= RESP_RETRY;
`endif
                        end else if (WAIT_STATES > 0) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= 4'(WAIT_STATES - 1);
                            rdy_q   <= 1'b0;
                            resp_q  <= RESP_OKAY;
                        end else begin
                            state_q <= ST_DATA;
                            rdy_q   <= 1'b1;
                            resp_q  <= RESP_OKAY;
                        end
                    end else begin
                        state_q <= ST_ADDR;
                        rdy_q   <= 1'b1;
                        resp_q  <= RESP_OKAY;
                    end
                end
            endcase
        end
    end

    always_comb begin
        case (size_q)
            2'd0:    size_bytes = 8'h01;
            2'd1:    size_bytes = 8'h03;
            2'd2:    size_bytes = 8'h0f;
            default: size_bytes = 8'hff;
        endcase
        lane_mask = size_bytes << lane_q;
    end

    // Contents survive reset; only the in-flight write is dropped.
    always_ff @(posedge CLK) begin
        if (!RST && state_q == ST_DATA && write_q) begin
            for (int b = 0; b < 8; b++) begin
                if (lane_mask[b]) mem_q[idx_q][b*8 +: 8] <= ahb.HWDATA[b*8 +: 8];
            end
        end
    end

    assign ahb.HREADYOUT = rdy_q;
    assign ahb.HRESP     = resp_q;
    assign ahb.HRDATA    = (state_q == ST_DATA && !write_q) ? mem_q[idx_q] : 64'd0;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two instances (no wait states / two wait states, different bases)
// on one shared master, each shadowed by a queue-of-cycles response model.
module tb_ahb_slave_mem;
    localparam int          DEPTH = 16;
    localparam logic [63:0] BASE0 = 64'h0;
    localparam logic [63:0] BASE1 = 64'h1000;
    localparam int          W0    = 0;
    localparam int          W1    = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    always #5 CLK = ~CLK;

    logic [1:0]  hsel;
    logic [63:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [63:0] hwdata;
`ifdef AHB_SLAVE_RETRY_EN
    logic        busy;
`endif
    bit          act;
    bit          chk_en;
    int          n_cmp = 0;
    int          n_err = 0;

    ahb_slave_mem_if bus0();
    ahb_slave_mem_if bus1();

    logic        hready;
    logic [1:0]  ro;
    logic [1:0]  rsp [2];
    logic [63:0] rd  [2];
    logic [63:0] hrd;
    logic [1:0]  hrs;

    assign ro     = {bus1.HREADYOUT, bus0.HREADYOUT};
    assign rsp[0] = bus0.HRESP;
    assign rsp[1] = bus1.HRESP;
    assign rd[0]  = bus0.HRDATA;
    assign rd[1]  = bus1.HRDATA;
    assign hready = act ? ro[1] : ro[0];
    assign hrd    = act ? rd[1] : rd[0];
    assign hrs    = act ? rsp[1] : rsp[0];

    assign bus0.HSEL = hsel[0];  assign bus1.HSEL = hsel[1];
    assign bus0.HADDR = haddr;   assign bus1.HADDR = haddr;
    assign bus0.HTRANS = htrans; assign bus1.HTRANS = htrans;
    assign bus0.HWRITE = hwrite; assign bus1.HWRITE = hwrite;
    assign bus0.HSIZE = hsize;   assign bus1.HSIZE = hsize;
    assign bus0.HBURST = hburst; assign bus1.HBURST = hburst;
    assign bus0.HWDATA = hwdata; assign bus1.HWDATA = hwdata;
    assign bus0.HREADY = hready; assign bus1.HREADY = hready;

    ahb_slave_mem #(.BASE_ADDR(BASE0), .MEM_DEPTH(DEPTH), .WAIT_STATES(W0)) dut0 (
        .CLK(CLK), .RST(RST),
`ifdef AHB_SLAVE_RETRY_EN
        .BUSY_IN(busy),
`endif
        .ahb(bus0.slave));

    ahb_slave_mem #(.BASE_ADDR(BASE1), .MEM_DEPTH(DEPTH), .WAIT_STATES(W1)) dut1 (
        .CLK(CLK), .RST(RST),
`ifdef AHB_SLAVE_RETRY_EN
        .BUSY_IN(busy),
`endif
        .ahb(bus1.slave));

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One entry per expected data-phase cycle: what the slave must show during that cycle.
    typedef struct {
        bit         rdy;
        logic [1:0] resp;
        bit         rd;
        bit         wr;
        int         idx;
        logic [7:0] mask;
    } ent_t;

    function automatic ent_t mk(input bit r, input logic [1:0] rs);
        ent_t e;
        e.rdy = r; e.resp = rs; e.rd = 0; e.wr = 0; e.idx = 0; e.mask = 8'h00;
        return e;
    endfunction

    function automatic logic [63:0] fillpat(input int k, input int i);
        return {16'hF111, 16'(k), 32'(i * 7 + 3)};
    endfunction

    for (genvar k = 0; k < 2; k++) begin : mdl
        localparam logic [63:0] B = (k == 0) ? BASE0 : BASE1;
        localparam int          W = (k == 0) ? W0 : W1;
        ent_t        q[$];
        logic [63:0] mem [DEPTH];
        ent_t        cur, e;
        bit          r, bad;
        logic [63:0] off;

        always @(posedge CLK) begin
            if (RST) begin
                q.delete();
            end else begin
                r = 1'b1;
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    r = cur.rdy;
                    if (cur.wr)
                        for (int b = 0; b < 8; b++)
                            if (cur.mask[b]) mem[cur.idx][b*8 +: 8] = hwdata[b*8 +: 8];
                end
                if (r && hsel[k] && htrans[1]) begin
                    off = haddr - B;
                    bad = (hsize > 3) || ((haddr & ((64'd1 << hsize) - 64'd1)) != 0) ||
                          (off >= 64'(DEPTH * 8));
                    if (bad) begin
                        q.push_back(mk(0, 2'd1));
                        q.push_back(mk(1, 2'd1));
`ifdef AHB_SLAVE_RETRY_EN
                    end else if (busy) begin
                        q.push_back(mk(0, 2'd2));
                        q.push_back(mk(1, 2'd2));
`endif
                    end else begin
                        repeat (W) q.push_back(mk(0, 2'd0));
                        e = mk(1, 2'd0);
                        e.rd = !hwrite;
                        e.wr = hwrite;
                        e.idx = int'(off / 8);
                        e.mask = 8'(((1 << (1 << hsize)) - 1) << haddr[2:0]);
                        q.push_back(e);
                    end
                end
            end
        end

        always @(negedge CLK) begin
            logic        eo;
            logic [1:0]  er;
            logic [63:0] ed;
            if (chk_en) begin
                eo = 1'b1; er = 2'd0; ed = 64'd0;
                if (q.size() > 0) begin
                    eo = q[0].rdy;
                    er = q[0].resp;
                    if (q[0].rd) ed = mem[q[0].idx];
                end
                chk($sformatf("d%0d HREADYOUT", k), 64'(ro[k]), 64'(eo));
                chk($sformatf("d%0d HRESP", k), 64'(rsp[k]), 64'(er));
                chk($sformatf("d%0d HRDATA", k), rd[k], ed);
            end
        end
    end

    task automatic wait_rdy(output logic [63:0] rdv, output int ncyc, output logic [1:0] rs);
        bit done;
        done = 0; ncyc = 0; rdv = 0; rs = 0;
        while (!done) begin
            @(negedge CLK);
            ncyc++;
            if (hready) begin
                rdv = hrd; rs = hrs; done = 1;
            end else if (ncyc >= 64) begin
                chk("ready timeout", 64'(hready), 64'd1);
                done = 1;
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic xfer(input bit wr, input logic [63:0] a, input logic [2:0] sz,
                        input logic [63:0] wd, output logic [63:0] rdv, output int ncyc,
                        output logic [1:0] rs);
        logic [63:0] d0; int n0; logic [1:0] r0;
        hsel = act ? 2'b10 : 2'b01; htrans = 2'd2; haddr = a; hwrite = wr; hsize = sz;
        wait_rdy(d0, n0, r0);
        hsel = 2'b00; htrans = 2'd0; hwdata = wd;
        wait_rdy(rdv, ncyc, rs);
    endtask

    task automatic rand_addr();
        logic [2:0]  sz;
        logic [63:0] a, base;
        int          p, o;
        base   = act ? BASE1 : BASE0;
        hsel   = ($urandom % 10 != 0) ? (act ? 2'b10 : 2'b01) : 2'b00;
        p      = $urandom % 8;
        htrans = (p < 2) ? 2'd0 : (p < 3) ? 2'd1 : (p < 6) ? 2'd2 : 2'd3;
        hwrite = 1'($urandom % 2);
        hburst = 3'($urandom % 8);
        sz     = ($urandom % 10 == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        o      = $urandom % 8;
        if (sz <= 3 && $urandom % 8 != 0) o = o & ~((1 << sz) - 1);
        a = base + 64'(8 * $urandom_range(0, DEPTH - 1)) + 64'(o);
        p = $urandom % 16;
        if (p == 0) a = base + 64'(DEPTH * 8) + 64'(8 * $urandom_range(0, 3));
        if (p == 1) a = base - 64'd8;
        haddr = a; hsize = sz;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [63:0] v;
        int          n, tot;
        logic [1:0]  rs;
        bit          r;
        hsel = 0; haddr = 0; htrans = 0; hwrite = 0; hsize = 0; hburst = 0; hwdata = 0;
`ifdef AHB_SLAVE_RETRY_EN
        busy = 0;
`endif
        act = 0; chk_en = 0; RST = 1;
        @(posedge CLK); #1; chk_en = 1;
        @(posedge CLK); #1; RST = 0;
        @(negedge CLK);
        chk("reset d0 HREADYOUT", 64'(ro[0]), 64'd1);
        chk("reset d1 HRESP", 64'(rsp[1]), 64'd0);
        chk("reset d0 HRDATA", rd[0], 64'd0);
        @(posedge CLK); #1;

        for (int k = 0; k < 2; k++) begin
            act = 1'(k);
            for (int i = 0; i < DEPTH; i++)
                xfer(1, (k ? BASE1 : BASE0) + 64'(i * 8), 3'd3, fillpat(k, i), v, n, rs);
        end

        // zero-wait instance: full word, byte merge, errors
        act = 0;
        xfer(1, 64'h10, 3'd3, 64'h1122334455667788, v, n, rs);
        chk("d0 write cycles", 64'(n), 64'd1);
        xfer(0, 64'h10, 3'd3, 64'h0, v, n, rs);
        chk("d0 read data", v, 64'h1122334455667788);
        chk("d0 read cycles", 64'(n), 64'd1);
        xfer(1, 64'h13, 3'd0, 64'h00000000AB000000, v, n, rs);
        xfer(0, 64'h10, 3'd3, 64'h0, v, n, rs);
        chk("d0 byte merge", v, 64'h11223344AB667788);
        xfer(0, BASE0 + 64'(DEPTH * 8), 3'd3, 64'h0, v, n, rs);
        chk("d0 oor resp", 64'(rs), 64'd1);
        chk("d0 oor cycles", 64'(n), 64'd2);
        xfer(1, 64'h2, 3'd2, 64'hDEADBEEFDEADBEEF, v, n, rs);
        chk("d0 misalign resp", 64'(rs), 64'd1);
        chk("d0 misalign cycles", 64'(n), 64'd2);
        xfer(0, 64'h0, 3'd3, 64'h0, v, n, rs);
        chk("d0 after error", v, fillpat(0, 0));

        // two-wait instance
        act = 1;
        xfer(1, BASE1 + 64'h10, 3'd3, 64'h1122334455667788, v, n, rs);
        chk("d1 write cycles", 64'(n), 64'd3);
        xfer(0, BASE1 + 64'h10, 3'd3, 64'h0, v, n, rs);
        chk("d1 read data", v, 64'h1122334455667788);
        chk("d1 read cycles", 64'(n), 64'd3);

        hsel = 2'b10; htrans = 2'd2; haddr = BASE1 + 64'h20; hwrite = 0; hsize = 3'd3;
        wait_rdy(v, n, rs);
        tot = 0;
        for (int i = 1; i < 4; i++) begin
            htrans = 2'd3; haddr = BASE1 + 64'h20 + 64'(8 * i);
            wait_rdy(v, n, rs);
            tot += n;
            chk($sformatf("d1 burst beat %0d", i - 1), v, fillpat(1, 4 + i - 1));
        end
        hsel = 2'b00; htrans = 2'd0;
        wait_rdy(v, n, rs);
        tot += n;
        chk("d1 burst beat 3", v, fillpat(1, 7));
        chk("d1 burst cycles", 64'(tot), 64'd12);

        xfer(0, BASE1 + 64'(DEPTH * 8), 3'd3, 64'h0, v, n, rs);
        chk("d1 oor resp", 64'(rs), 64'd1);
        chk("d1 oor cycles", 64'(n), 64'd2);
        xfer(0, BASE1 - 64'd8, 3'd3, 64'h0, v, n, rs);
        chk("d1 below base resp", 64'(rs), 64'd1);

        // reset lands on the second wait cycle of a write
        hsel = 2'b10; htrans = 2'd2; haddr = BASE1 + 64'h18; hwrite = 1; hsize = 3'd3;
        wait_rdy(v, n, rs);
        hsel = 2'b00; htrans = 2'd0; hwdata = 64'h5555AAAA5555AAAA;
        @(posedge CLK); #1;
        RST = 1;
        @(posedge CLK); #1;
        RST = 0;
        @(negedge CLK);
        chk("post-reset HREADYOUT", 64'(ro[1]), 64'd1);
        chk("post-reset HRESP", 64'(rsp[1]), 64'd0);
        chk("post-reset HRDATA", rd[1], 64'd0);
        @(posedge CLK); #1;
        xfer(0, BASE1 + 64'h18, 3'd3, 64'h0, v, n, rs);
        chk("d1 aborted write", v, fillpat(1, 3));

`ifdef AHB_SLAVE_RETRY_EN
        act = 0; busy = 1;
        xfer(1, 64'h20, 3'd3, 64'hCAFEF00DCAFEF00D, v, n, rs);
        chk("retry resp", 64'(rs), 64'd2);
        chk("retry cycles", 64'(n), 64'd2);
        busy = 0;
        xfer(0, 64'h20, 3'd3, 64'h0, v, n, rs);
        chk("retry no write", v, fillpat(0, 4));
        xfer(1, 64'h20, 3'd3, 64'hCAFEF00DCAFEF00D, v, n, rs);
        chk("reissue resp", 64'(rs), 64'd0);
        xfer(0, 64'h20, 3'd3, 64'h0, v, n, rs);
        chk("reissue data", v, 64'hCAFEF00DCAFEF00D);
`endif

        for (int k = 0; k < 2; k++) begin
            act = 1'(k);
            for (int c = 0; c < 400; c++) begin
                @(negedge CLK);
                r = hready;
                @(posedge CLK); #1;
`ifdef AHB_SLAVE_RETRY_EN
                busy = ($urandom % 4 == 0);
`endif
                if (r) begin
                    hwdata = {$urandom, $urandom};
                    rand_addr();
                end
            end
            hsel = 2'b00; htrans = 2'd0;
            wait_rdy(v, n, rs);
            wait_rdy(v, n, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- Synthesizable AHB slave responder: the other end of the AHB master interface, backed by an internal 64-bit-wide register memory.
- Decodes address/control in the address phase and completes reads/writes in the data phase.
- Inserts a programmable number of wait states and generates two-cycle ERROR responses.
- Used as the default memory target on the AHB fabric and as the closed-loop partner when testing the master protocol model.

Parameters:
- BASE_ADDR, 64'h0, byte address of memory word 0.
- MEM_DEPTH, 256, number of 64-bit words; must be a power of two.
- WAIT_STATES, 0, wait cycles inserted per OKAY transfer (0..15).

Ports:
- CLK  input  1  bus clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- HSEL  input  1  slave select from decoder.
- HADDR  input  64  byte address.
- HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  transfer size, log2 bytes.
- HBURST  input  3  burst type; accepted but not checked.
- HWDATA  input  64  write data, valid in data phase.
- HREADY  input  1  global bus ready (address phase qualifier).
- HREADYOUT  output  1  slave ready.
- HRESP  output  2  OKAY=0, ERROR=1, RETRY=2, SPLIT=3.
- HRDATA  output  64  read data.

Behaviour:
- Reset (RST high at posedge):
  - State goes to ADDR; wait counter = 0; latched controls cleared.
  - HREADYOUT=1, HRESP=OKAY, HRDATA=0.
  - Memory contents are not cleared.
  - A reset mid-transfer abandons that transfer; no memory write occurs on the reset edge.
- Accepting a transfer:
  - A transfer is accepted at a posedge when HSEL && HREADY && HTRANS in {NONSEQ, SEQ}.
  - On acceptance, latch addr, write, size.
  - IDLE/BUSY transfers, or HSEL=0: next cycle is a zero-wait OKAY; nothing is latched.
- Error check (at acceptance):
  - ERROR if any of: HSIZE>3, address misaligned to HSIZE, or (HADDR-BASE_ADDR) >= MEM_DEPTH*8 (unsigned compare).
- States:
  - ADDR: HREADYOUT=1, HRESP=OKAY.
    - Accepted and legal with WAIT_STATES>0 -> WAIT, counter = WAIT_STATES-1.
    - Accepted and legal with WAIT_STATES=0 -> DATA.
    - Accepted and illegal -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=OKAY. Counter decrements each cycle; moves to DATA when counter=0.
  - DATA: HREADYOUT=1, HRESP=OKAY.
    - Write: commits HWDATA lanes to memory at the end of this cycle.
    - Read: HRDATA = mem[word index] (combinational from the latched address).
    - Behaves as ADDR for a pipelined next transfer: back-to-back transfers with WAIT_STATES=0 complete one per cycle.
  - ERR1: HREADYOUT=0, HRESP=ERROR -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR; behaves as ADDR for acceptance. A master following protocol drives IDLE here.
- Byte lanes:
  - Little-endian; lane mask = ((1<<(1<<size))-1) << addr[2:0].
  - Only masked bytes are written.
  - Reads return the full 64-bit word; the master selects lanes.
- Word index = (addr-BASE_ADDR)[log2(MEM_DEPTH)+2:3].
- Read-after-write to the same word on consecutive transfers returns the new data; no hazard.
- HRDATA = 0 in every cycle other than a read DATA cycle.
- HWDATA is ignored outside a write DATA cycle.
- Latency: with W = WAIT_STATES, an OKAY transfer's data phase lasts W+1 cycles; an ERROR transfer's lasts exactly 2 cycles, regardless of W.

Optional Feature:
- Macro: AHB_SLAVE_RETRY_EN.
- When defined:
  - Adds input port BUSY_IN (1 bit).
  - A legal transfer accepted while BUSY_IN=1 gets a two-cycle RETRY response instead of WAIT/DATA: RTY1 (HREADYOUT=0, HRESP=RETRY), then RTY2 (HREADYOUT=1, HRESP=RETRY).
  - No memory access occurs on a retried transfer.
  - ERROR takes priority over RETRY.
- When undefined: no BUSY_IN port, RETRY is never driven, and the RTY states do not exist.

Test Plan:
- Reset, then NONSEQ write HADDR=0x10, HSIZE=3, HWDATA=0x1122334455667788, WAIT_STATES=0 -> 1-cycle OKAY. Read of 0x10 next transfer -> HRDATA=0x1122334455667788, HREADYOUT=1.
- Byte write HADDR=0x13, HSIZE=0, HWDATA=0x00000000AB000000 over the previous word -> read of 0x10 returns 0x11223344AB667788.
- WAIT_STATES=2, NONSEQ read -> HREADYOUT low exactly 2 cycles, then high with OKAY and valid data. 4-beat SEQ burst -> 12 total data-phase cycles.
- Read HADDR=BASE_ADDR+MEM_DEPTH*8 (out of range), and HSIZE=2 at HADDR=0x2 (misaligned) -> each gets HREADYOUT 0 then 1 with HRESP=ERROR both cycles; memory unchanged.
- Assert RST during the 2nd wait cycle of a write -> next cycle HREADYOUT=1, HRESP=OKAY, HRDATA=0; subsequent read of that address returns the old data.
- AHB_SLAVE_RETRY_EN defined, BUSY_IN=1, NONSEQ write -> two-cycle RETRY, no write. Reissue with BUSY_IN=0 -> OKAY, data written.
